nucore_trace_buffer: RTL and testbench

//  Parametrised on-chip execution trace capture for the NuCore core. Sits beside the core and snoops
//  IF_PC, IF_opcode, ALUresult and Zero. Keeps a circular pre-trigger history, stops after a PC-match

---
 rtl/nucore_trace_buffer.sv | 158 +++++++++++++++
 tb/tb_nucore_trace_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nucore_trace_buffer.sv
// Execution trace capture for NuCore: circular pre-trigger history, PC-match trigger, POST_TRIG tail, 1-cycle read port.
// Optional build macro NUCORE_TRACE_TSTAMP_EN appends a 16-bit cycle timestamp to every entry.
module nucore_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 6,
  parameter int OPC_W     = 3,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW       = $clog2(DEPTH),
`ifdef NUCORE_TRACE_TSTAMP_EN
  localparam int ENT_W    = PC_W + OPC_W + DATA_W + 17
`else
  localparam int ENT_W    = PC_W + OPC_W + DATA_W + 1
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [PC_W-1:0]   trig_pc_i,
  input  logic              smp_vld_i,
  input  logic [PC_W-1:0]   IF_PC,
  input  logic [OPC_W-1:0]  IF_opcode,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic              Zero,
  input  logic              rd_req_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_err_o,
  output logic [ENT_W-1:0]  rd_data_o,
  output logic [1:0]        state_o,
  output logic [AW:0]       entries_o,
  output logic [AW-1:0]     trig_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LD = AW'(POST_TRIG);
  localparam bit            NO_POST = (POST_TRIG == 0);

  state_t               state, state_d;
  logic [AW-1:0]        wr_ptr, post_cnt, trig_slot, oldest, rd_addr;
  logic [AW:0]          entries;
  logic                 wr_en, clr, trig_hit, rd_err_d;
  logic [ENT_W-1:0]     mem [DEPTH];
  logic [ENT_W-1:0]     wr_data;

`ifdef NUCORE_TRACE_TSTAMP_EN
  logic [15:0] tstamp;

  // Zero in the first cycle after the arm edge, then free-running, stalls included.
  always_ff @(posedge Clk) begin
    if (Rst || clr) tstamp <= '0;
    else            tstamp <= tstamp + 16'd1;
  end

  assign wr_data = {IF_PC, IF_opcode, ALUresult, Zero, tstamp};
`else
  assign wr_data = {IF_PC, IF_opcode, ALUresult, Zero};
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state;
    wr_en    = 1'b0;
    clr      = 1'b0;
    trig_hit = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (arm_i) begin
          state_d = S_ARMED;
          clr     = 1'b1;
        end
      end
      S_ARMED: begin
        if (smp_vld_i) begin
          wr_en = 1'b1;
          if (IF_PC == trig_pc_i) begin
            trig_hit = 1'b1;
            state_d  = NO_POST ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (smp_vld_i) begin
          wr_en = 1'b1;
          if (post_cnt == AW'(1)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides arm and trigger alike.
    if (abort_i) begin
      state_d  = S_IDLE;
      wr_en    = 1'b0;
      trig_hit = 1'b0;
      clr      = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      entries   <= '0;
      post_cnt  <= '0;
      trig_slot <= '0;
    end else begin
      state <= state_d;
      if (clr) begin
        wr_ptr  <= '0;
        entries <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (entries != FULL) entries <= entries + (AW+1)'(1);
      end
      if (trig_hit) begin
        trig_slot <= wr_ptr;
        post_cnt  <= POST_LD;
      end else if (wr_en && state == S_POST) begin
        post_cnt <= post_cnt - AW'(1);
      end
    end
  end

  // NOTE: trace storage has no reset; stale contents are unreachable because reads are gated by entries.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign oldest   = (entries == FULL) ? wr_ptr : '0;
  assign rd_addr  = oldest + rd_idx_i;
  assign rd_err_d = (state != S_DONE) || ({1'b0, rd_idx_i} >= entries);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      rd_err_o   <= rd_req_i && rd_err_d;
      rd_data_o  <= (rd_req_i && !rd_err_d) ? mem[rd_addr] : '0;
    end
  end

  assign state_o    = state;
  assign entries_o  = entries;
  assign trig_idx_o = (state == S_DONE) ? (trig_slot - oldest) : '0;

endmodule

// File: tb/tb_nucore_trace_buffer.sv
// Directed bench for nucore_trace_buffer: reset mid-capture, wrap/no-wrap captures, abort, gated samples.
// Timestamp checks are compiled in when NUCORE_TRACE_TSTAMP_EN is defined.
module tb_nucore_trace_buffer;

  localparam int DATA_W = 32;
  localparam int PC_W   = 6;
  localparam int OPC_W  = 3;
  localparam int AW     = 4;
`ifdef NUCORE_TRACE_TSTAMP_EN
  localparam int ENT_W  = PC_W + OPC_W + DATA_W + 17;
`else
  localparam int ENT_W  = PC_W + OPC_W + DATA_W + 1;
`endif

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              arm_i = 1'b0, abort_i = 1'b0, smp_vld_i = 1'b0, Zero;
  logic [PC_W-1:0]   trig_pc_i = '0, IF_PC = '0;
  logic [OPC_W-1:0]  IF_opcode;
  logic [DATA_W-1:0] ALUresult;
  logic              rd_req_i = 1'b0;
  logic [AW-1:0]     rd_idx_i = '0;
  logic              rd_valid_o, rd_err_o;
  logic [ENT_W-1:0]  rd_data_o;
  logic [1:0]        state_o;
  logic [AW:0]       entries_o;
  logic [AW-1:0]     trig_idx_o;

  int n_vec  = 0;
  int n_fail = 0;

  // Side-band fields are derived from the PC so any entry can be checked in full.
  assign IF_opcode = IF_PC[OPC_W-1:0];
  assign ALUresult = DATA_W'(IF_PC) * 3;
  assign Zero      = (IF_PC == '0);

  nucore_trace_buffer dut (
    .Clk(Clk), .Rst(Rst), .arm_i(arm_i), .abort_i(abort_i), .trig_pc_i(trig_pc_i),
    .smp_vld_i(smp_vld_i), .IF_PC(IF_PC), .IF_opcode(IF_opcode), .ALUresult(ALUresult),
    .Zero(Zero), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_valid_o(rd_valid_o),
    .rd_err_o(rd_err_o), .rd_data_o(rd_data_o), .state_o(state_o), .entries_o(entries_o),
    .trig_idx_o(trig_idx_o)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arm, then feed PC = cycle count until DONE or max_cyc; toggle gates every other sample.
  task automatic capture(input int trig, input bit toggle, input int max_cyc, output int writes);
    int cyc;
    trig_pc_i = PC_W'(trig);
    @(negedge Clk); arm_i = 1'b1;
    @(negedge Clk); arm_i = 1'b0;
    cyc    = 0;
    writes = 0;
    while (state_o != 2'b11 && cyc < max_cyc) begin
      smp_vld_i = toggle ? (cyc % 2 == 0) : 1'b1;
      IF_PC     = PC_W'(cyc);
      @(negedge Clk);
      if (smp_vld_i) writes++;
      cyc++;
    end
    smp_vld_i = 1'b0;
  endtask

  task automatic read(input int idx, output logic vld, output logic err, output logic [ENT_W-1:0] data);
    rd_req_i = 1'b1;
    rd_idx_i = AW'(idx);
    @(negedge Clk);
    rd_req_i = 1'b0;
    vld  = rd_valid_o;
    err  = rd_err_o;
    data = rd_data_o;
  endtask

  function automatic logic [63:0] pc_of(input logic [ENT_W-1:0] d);
    return 64'(d[ENT_W-1 -: PC_W]);
  endfunction

  logic             v, e;
  logic [ENT_W-1:0] d;
  int               w;

  initial begin
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // 1: reset in the middle of POST, with a read presented during reset
    capture(20, 1'b0, 24, w);
    check("pre_rst_state", 64'(state_o), 64'd2);
    Rst = 1'b1; rd_req_i = 1'b1;
    @(negedge Clk); @(negedge Clk);
    check("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    Rst = 1'b0; rd_req_i = 1'b0;
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_entries", 64'(entries_o), 64'd0);
    check("rst_trig_idx", 64'(trig_idx_o), 64'd0);
    @(negedge Clk);
    check("post_rst_no_resp", 64'(rd_valid_o), 64'd0);
    read(0, v, e, d);
    check("idle_rd_valid", 64'(v), 64'd1);
    check("idle_rd_err", 64'(e), 64'd1);
    check("idle_rd_data", 64'(d), 64'd0);

    // 2: wrapped capture, trigger at PC 20
    capture(20, 1'b0, 100, w);
    check("s2_writes", 64'(w), 64'd29);
    check("s2_state", 64'(state_o), 64'd3);
    check("s2_entries", 64'(entries_o), 64'd16);
    check("s2_trig_idx", 64'(trig_idx_o), 64'd7);
    read(0, v, e, d);
    check("s2_idx0_pc", pc_of(d), 64'd13);
    check("s2_idx0_err", 64'(e), 64'd0);
`ifdef NUCORE_TRACE_TSTAMP_EN
    check("s2_idx0_ts", 64'(d[15:0]), 64'd13);
`endif
    read(7, v, e, d);
    check("s2_idx7_pc", pc_of(d), 64'd20);
    check("s2_idx7_opc", 64'(d[ENT_W-PC_W-1 -: OPC_W]), 64'd4);
    check("s2_idx7_alu", 64'(d[ENT_W-PC_W-OPC_W-1 -: DATA_W]), 64'd60);
    // Back-to-back reads: idx15 requested while idx14 response is presented
    rd_req_i = 1'b1; rd_idx_i = 4'd14;
    @(negedge Clk);
    rd_idx_i = 4'd15;
    check("s2_b2b_idx14_pc", pc_of(rd_data_o), 64'd27);
    @(negedge Clk);
    rd_req_i = 1'b0;
    check("s2_b2b_valid", 64'(rd_valid_o), 64'd1);
    check("s2_idx15_pc", pc_of(rd_data_o), 64'd28);
`ifdef NUCORE_TRACE_TSTAMP_EN
    check("s2_idx15_ts", 64'(rd_data_o[15:0]), 64'd28);
`endif
    // Frozen in DONE: further valid samples are not written
    smp_vld_i = 1'b1; IF_PC = 6'd50;
    repeat (3) @(negedge Clk);
    smp_vld_i = 1'b0;
    check("s2_frozen_entries", 64'(entries_o), 64'd16);
    read(15, v, e, d);
    check("s2_frozen_idx15", pc_of(d), 64'd28);

    // 3: capture without wrap, trigger at PC 2
    capture(2, 1'b0, 100, w);
    check("s3_state", 64'(state_o), 64'd3);
    check("s3_entries", 64'(entries_o), 64'd11);
    check("s3_trig_idx", 64'(trig_idx_o), 64'd2);
    read(0, v, e, d);
    check("s3_idx0_pc", pc_of(d), 64'd0);
    read(10, v, e, d);
    check("s3_idx10_pc", pc_of(d), 64'd10);
    check("s3_idx10_err", 64'(e), 64'd0);
    read(11, v, e, d);
    check("s3_idx11_valid", 64'(v), 64'd1);
    check("s3_idx11_err", 64'(e), 64'd1);
    check("s3_idx11_data", 64'(d), 64'd0);

    // 4: abort and arm together in POST
    capture(20, 1'b0, 24, w);
    check("s4_in_post", 64'(state_o), 64'd2);
    abort_i = 1'b1; arm_i = 1'b1;
    @(negedge Clk);
    abort_i = 1'b0; arm_i = 1'b0;
    check("s4_state", 64'(state_o), 64'd0);
    check("s4_entries", 64'(entries_o), 64'd0);
    smp_vld_i = 1'b1; IF_PC = 6'd20;
    repeat (4) @(negedge Clk);
    smp_vld_i = 1'b0;
    check("s4_idle_state", 64'(state_o), 64'd0);
    check("s4_idle_entries", 64'(entries_o), 64'd0);

    // 5: every other sample gated off, trigger at PC 20
    capture(20, 1'b1, 100, w);
    check("s5_writes", 64'(w), 64'd19);
    check("s5_state", 64'(state_o), 64'd3);
    check("s5_entries", 64'(entries_o), 64'd16);
    check("s5_trig_idx", 64'(trig_idx_o), 64'd7);
    read(0, v, e, d);
    check("s5_idx0_pc", pc_of(d), 64'd6);
    read(15, v, e, d);
    check("s5_idx15_pc", pc_of(d), 64'd36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
